// File: rtl/prescaler_pwm_breather_if.sv
// Signal bundle between a prescaler-side driver and the PWM breather.
// The driver owns the tick source selection and run control; the breather owns the outputs.
interface prescaler_pwm_breather_if #(
   parameter int unsigned PRESCALER_WIDTH = 4,
   parameter int unsigned PWM_WIDTH       = 3
);

   localparam int unsigned TapW = (PRESCALER_WIDTH > 1) ? $clog2(PRESCALER_WIDTH) : 1;

   logic [PRESCALER_WIDTH-1:0] prescale_in;
   logic [TapW-1:0]            tap_sel;
   logic                       enable;
   logic                       tick_out;
   logic                       period_end;
   logic                       pwm_out;
   logic [PWM_WIDTH-1:0]       duty_out;

   modport master (
      output prescale_in,
      output tap_sel,
      output enable,
      input  tick_out,
      input  period_end,
      input  pwm_out,
      input  duty_out
   );

   modport slave (
      input  prescale_in,
      input  tap_sel,
      input  enable,
      output tick_out,
      output period_end,
      output pwm_out,
      output duty_out
   );

endinterface

// File: rtl/prescaler_pwm_breather.sv
// Turns rising edges of a selected prescaler bit into ticks that clock a PWM counter whose
// duty ramps up, holds, ramps down and holds again ("breathing" waveform).
module prescaler_pwm_breather #(
   parameter int unsigned PRESCALER_WIDTH = 4,
   parameter int unsigned PWM_WIDTH       = 3,
   parameter int unsigned STEP            = 2,
   parameter int unsigned HOLD_PERIODS    = 1
) (
   input logic                     clk,
   input logic                     rst_n,
   prescaler_pwm_breather_if.slave bus
);

   localparam int unsigned          HoldW    = $clog2(HOLD_PERIODS + 2);
   localparam logic [PWM_WIDTH-1:0] DutyMax  = {PWM_WIDTH{1'b1}};
   localparam logic [PWM_WIDTH:0]   StepExt  = (PWM_WIDTH + 1)'(STEP);
   localparam logic [HoldW-1:0]     HoldLast = HoldW'(HOLD_PERIODS);

   typedef enum logic [1:0] {
      StRampUp,
      StHoldHigh,
      StRampDown,
      StHoldLow
   } state_e;

   state_e                     state_q, state_d;
   logic [PRESCALER_WIDTH-1:0] prev_q;
   logic                       primed_q;
   logic                       tick_q;
   logic                       period_end_q;
   logic                       pwm_q;
   logic [PWM_WIDTH-1:0]       pwm_cnt_q, pwm_cnt_d;
   logic [PWM_WIDTH-1:0]       duty_q, duty_d;
   logic [HoldW-1:0]           hold_cnt_q, hold_cnt_d;

   logic                       tap_valid;
   logic                       tap_cur;
   logic                       tap_prev;
   logic                       edge_det;
   logic                       wrap;
   logic [PWM_WIDTH:0]         duty_sum;
   logic [PWM_WIDTH-1:0]       duty_up;
   logic [PWM_WIDTH-1:0]       duty_dn;
   logic [HoldW-1:0]           hold_inc;

   // Both current and previous bits come from the same tap, so a tap change cannot fake an edge.
   always_comb begin
      tap_valid = 32'(bus.tap_sel) < PRESCALER_WIDTH;
      tap_cur   = 1'b0;
      tap_prev  = 1'b0;
      if (tap_valid) begin
         tap_cur  = bus.prescale_in[bus.tap_sel];
         tap_prev = prev_q[bus.tap_sel];
      end
      edge_det = tap_cur & ~tap_prev & primed_q;
   end

   assign wrap = tick_q & (pwm_cnt_q == DutyMax);

   always_comb begin
      pwm_cnt_d = pwm_cnt_q;
      if (tick_q) begin
         pwm_cnt_d = wrap ? '0 : pwm_cnt_q + 1'b1;
      end
   end

   // Saturating duty arithmetic with one guard bit on the way up.
   always_comb begin
      duty_sum = {1'b0, duty_q} + StepExt;
      duty_up  = (duty_sum > {1'b0, DutyMax}) ? DutyMax : duty_sum[PWM_WIDTH-1:0];
      duty_dn  = ({1'b0, duty_q} > StepExt) ? duty_q - StepExt[PWM_WIDTH-1:0] : '0;
      hold_inc = hold_cnt_q + 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      duty_d     = duty_q;
      hold_cnt_d = hold_cnt_q;
      if (wrap) begin
         unique case (state_q)
            StRampUp: begin
               duty_d = duty_up;
               if (duty_up == DutyMax) begin
                  hold_cnt_d = '0;
                  state_d    = (HOLD_PERIODS == 0) ? StRampDown : StHoldHigh;
               end
            end
            StHoldHigh: begin
               if (hold_inc >= HoldLast) begin
                  hold_cnt_d = '0;
                  state_d    = StRampDown;
               end else begin
                  hold_cnt_d = hold_inc;
               end
            end
            StRampDown: begin
               duty_d = duty_dn;
               if (duty_dn == '0) begin
                  hold_cnt_d = '0;
                  state_d    = (HOLD_PERIODS == 0) ? StRampUp : StHoldLow;
               end
            end
            StHoldLow: begin
               if (hold_inc >= HoldLast) begin
                  hold_cnt_d = '0;
                  state_d    = StRampUp;
               end else begin
                  hold_cnt_d = hold_inc;
               end
            end
            default: begin
               state_d    = StRampUp;
               hold_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q       <= '0;
         primed_q     <= 1'b0;
         tick_q       <= 1'b0;
         period_end_q <= 1'b0;
         pwm_q        <= 1'b0;
         pwm_cnt_q    <= '0;
         duty_q       <= '0;
         hold_cnt_q   <= '0;
         state_q      <= StRampUp;
      end else begin
         prev_q       <= bus.prescale_in;
         primed_q     <= 1'b1;
         tick_q       <= edge_det & bus.enable;
         period_end_q <= wrap;
         pwm_q        <= bus.enable & (pwm_cnt_q < duty_q);
         pwm_cnt_q    <= pwm_cnt_d;
         duty_q       <= duty_d;
         hold_cnt_q   <= hold_cnt_d;
         state_q      <= state_d;
      end
   end

   assign bus.tick_out   = tick_q;
   assign bus.period_end = period_end_q;
   assign bus.pwm_out    = pwm_q;
   assign bus.duty_out   = duty_q;

   a_pe_after_tick : assert property (@(posedge clk) disable iff (!rst_n)
      period_end_q |-> $past(tick_q));

   a_pwm_needs_enable : assert property (@(posedge clk) disable iff (!rst_n)
      pwm_q |-> $past(bus.enable));

   a_hold_levels : assert property (@(posedge clk) disable iff (!rst_n)
      ((state_q == StHoldHigh) |-> (duty_q == DutyMax)) and
      ((state_q == StHoldLow) |-> (duty_q == '0)));

endmodule

// File: tb/tb_prescaler_pwm_breather.sv
// Directed bench for prescaler_pwm_breather with a free-running 4-bit prescaler stimulus.
module tb_prescaler_pwm_breather;

   logic       clk;
   logic       rst_n;
   int         n_tests = 0;
   int         n_fail  = 0;
   bit         free_run = 1'b0;
   logic [3:0] edge_val = '0;
   logic [3:0] prev_val = '0;

   prescaler_pwm_breather_if #(.PRESCALER_WIDTH(4), .PWM_WIDTH(3)) bus ();

   prescaler_pwm_breather #(
      .PRESCALER_WIDTH(4),
      .PWM_WIDTH      (3),
      .STEP           (2),
      .HOLD_PERIODS   (1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One clock; records the prescaler value the DUT sampled on this edge and the one before.
   task automatic step();
      prev_val = edge_val;
      edge_val = bus.prescale_in;
      @(posedge clk);
      #1;
      if (free_run) bus.prescale_in = bus.prescale_in + 4'd1;
   endtask

   task automatic apply_reset();
      bus.enable = 1'b0;
      rst_n      = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_duty(input int target, input int budget);
      int n     = 0;
      bit found = 1'b0;
      while (!found && n < budget) begin
         step();
         n++;
         found = bus.period_end && (32'(bus.duty_out) == target);
      end
      check($sformatf("wait_duty%0d", target), 32'(found), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_duty[11] = '{2, 4, 6, 7, 7, 5, 3, 1, 0, 0, 2};
      int ticks;
      int n;
      int pe_seen;
      int cyc;
      int last_pe;
      int hi;
      int prev_duty;
      logic exp_tick;

      // Reset held with bit0 already high; first cycle after release must stay quiet.
      rst_n           = 1'b0;
      bus.prescale_in = 4'd1;
      bus.tap_sel     = 2'd0;
      bus.enable      = 1'b1;
      step();
      step();
      check("rst_tick", 32'(bus.tick_out), 0);
      check("rst_pe", 32'(bus.period_end), 0);
      check("rst_pwm", 32'(bus.pwm_out), 0);
      check("rst_duty", 32'(bus.duty_out), 0);
      rst_n = 1'b1;
      step();
      check("primed_tick", 32'(bus.tick_out), 0);
      step();
      check("primed_tick2", 32'(bus.tick_out), 0);
      free_run = 1'b1;

      // Tick rate on tap 0 then tap 2.
      apply_reset();
      bus.tap_sel = 2'd0;
      bus.enable  = 1'b1;
      repeat (3) step();
      ticks = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         exp_tick = edge_val[bus.tap_sel] & ~prev_val[bus.tap_sel];
         ticks += int'(bus.tick_out);
         check("tick_tap0", 32'(bus.tick_out), 32'(exp_tick));
      end
      check("tick_cnt_tap0", ticks, 8);
      bus.tap_sel = 2'd2;
      step();
      ticks = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         exp_tick = edge_val[bus.tap_sel] & ~prev_val[bus.tap_sel];
         ticks += int'(bus.tick_out);
         check("tick_tap2", 32'(bus.tick_out), 32'(exp_tick));
      end
      check("tick_cnt_tap2", ticks, 4);

      // Ramp sequence, period spacing and PWM high time per period.
      apply_reset();
      bus.tap_sel = 2'd0;
      bus.enable  = 1'b1;
      pe_seen     = 0;
      cyc         = 0;
      last_pe     = 0;
      hi          = 0;
      prev_duty   = 0;
      while (pe_seen < 11 && cyc < 400) begin
         step();
         cyc++;
         hi += int'(bus.pwm_out);
         if (bus.period_end) begin
            check($sformatf("ramp_duty%0d", pe_seen), 32'(bus.duty_out), exp_duty[pe_seen]);
            if (pe_seen > 0) begin
               check("pe_gap", cyc - last_pe, 16);
               check($sformatf("pwm_high_d%0d", prev_duty), hi, 2 * prev_duty);
            end
            prev_duty = exp_duty[pe_seen];
            hi        = 0;
            last_pe   = cyc;
            pe_seen++;
         end
      end
      check("pe_count", pe_seen, 11);

      // Freeze at duty 4, pwm_cnt 3 for 20 clocks.
      apply_reset();
      bus.tap_sel = 2'd0;
      bus.enable  = 1'b1;
      wait_duty(4, 200);
      repeat (6) step();
      check("frz_cnt_before", 32'(dut.pwm_cnt_q), 3);
      check("frz_pwm_before", 32'(bus.pwm_out), 1);
      bus.enable = 1'b0;
      ticks = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         ticks += int'(bus.tick_out) + int'(bus.pwm_out) + int'(bus.period_end);
      end
      check("frz_outputs_active", ticks, 0);
      check("frz_duty", 32'(bus.duty_out), 4);
      check("frz_cnt", 32'(dut.pwm_cnt_q), 3);
      check("frz_state", 32'(dut.state_q), 0);
      bus.enable = 1'b1;
      n = 0;
      ticks = 0;
      while (!bus.period_end && n < 40) begin
         step();
         n++;
         ticks += int'(bus.tick_out);
      end
      check("resume_clks", n, 10);
      check("resume_ticks", ticks, 5);
      check("resume_duty", 32'(bus.duty_out), 6);

      // Asynchronous reset in HOLD_HIGH.
      apply_reset();
      bus.tap_sel = 2'd0;
      bus.enable  = 1'b1;
      wait_duty(7, 200);
      repeat (3) step();
      check("hold_state", 32'(dut.state_q), 1);
      check("hold_pwm", 32'(bus.pwm_out), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_duty", 32'(bus.duty_out), 0);
      check("arst_pwm", 32'(bus.pwm_out), 0);
      check("arst_tick", 32'(bus.tick_out), 0);
      check("arst_pe", 32'(bus.period_end), 0);
      check("arst_state", 32'(dut.state_q), 0);
      check("arst_cnt", 32'(dut.pwm_cnt_q), 0);
      step();
      rst_n = 1'b1;

      // Tap change 0 -> 3 with bit3=1, bit0=0 on the next sampled value (10).
      apply_reset();
      bus.tap_sel = 2'd0;
      bus.enable  = 1'b1;
      n = 0;
      while (bus.prescale_in != 4'd10 && n < 40) begin
         step();
         n++;
      end
      check("tap_sync", 32'(bus.prescale_in), 10);
      bus.tap_sel = 2'd3;
      ticks = 0;
      for (int i = 1; i <= 14; i++) begin
         step();
         ticks += int'(bus.tick_out);
      end
      check("tap_no_spurious", ticks, 0);
      step();
      check("tap3_tick", 32'(bus.tick_out), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
